// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a transmit source and the UART transmit controller.
// The source offers tx_data with tx_valid; the controller answers with tx_ready.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, DATA_BITS LSB first, stop bit(s), one per baud tick.
// Define UART_TX_PARITY_EN to insert a parity bit after the last data bit.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_i,
    uart_tx_ctrl_if.slave tx_if,
    input  logic          clk_bps_i,
    output logic          bps_start_o,
    output logic          tx_o,
    output logic          tx_busy_o,
    output logic          tx_done_o
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_e;

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS);

    state_e               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bitcnt_q;
    logic [1:0]           stopcnt_q;
    logic                 tx_q;
    logic                 bps_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic par_q;
    logic par_d;

    // Parity is frozen from the byte as it is accepted.
    assign par_d = (^tx_if.tx_data) ^ (PARITY_ODD != 0);
`endif

    assign accept = tx_if.tx_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= '0;
            tx_q      <= 1'b1;
            bps_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (!in_i) begin
            // Disable abandons any partial frame without a done pulse.
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            stopcnt_q <= '0;
            tx_q      <= 1'b1;
            bps_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    done_q <= 1'b0;
                    if (accept) begin
                        shift_q <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= par_d;
`endif
                        state_q <= WAIT;
                        bps_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (clk_bps_i) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (clk_bps_i) begin
                        state_q  <= DATA;
                        tx_q     <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bitcnt_q <= 4'd1;
                    end
                end
                DATA: begin
                    if (clk_bps_i) begin
                        if (bitcnt_q < LAST_BIT) begin
                            tx_q     <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_q      <= par_q;
`else
                            state_q   <= STOP;
                            tx_q      <= 1'b1;
                            stopcnt_q <= 2'd1;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (clk_bps_i) begin
                        state_q   <= STOP;
                        tx_q      <= 1'b1;
                        stopcnt_q <= 2'd1;
                    end
                end
`endif
                STOP: begin
                    if (clk_bps_i) begin
                        if (stopcnt_q < LAST_STOP) begin
                            stopcnt_q <= stopcnt_q + 2'd1;
                        end else begin
                            state_q <= DONE;
                            tx_q    <= 1'b1;
                            bps_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    bps_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.tx_ready = ready_q;
    assign bps_start_o    = bps_q;
    assign tx_o           = tx_q;
    assign tx_busy_o      = busy_q;
    assign tx_done_o      = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: lane 0 is 8N1, lane 1 is 8 data / 2 stop / odd parity.
// A frame-level model predicts every output each cycle; directed frames pin it.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en    [2];
    logic       valid [2];
    logic [7:0] data  [2];
    logic       tick  [2] = '{1'b0, 1'b0};
    logic       txo [2];
    logic       bps [2];
    logic       busy[2];
    logic       dn  [2];
    logic       rdy [2];

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();

    assign if0.tx_data  = data[0];
    assign if0.tx_valid = valid[0];
    assign rdy[0]       = if0.tx_ready;
    assign if1.tx_data  = data[1];
    assign if1.tx_valid = valid[1];
    assign rdy[1]       = if1.tx_ready;

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .in_i(en[0]), .tx_if(if0),
        .clk_bps_i(tick[0]), .bps_start_o(bps[0]), .tx_o(txo[0]),
        .tx_busy_o(busy[0]), .tx_done_o(dn[0])
    );

    uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst(rst), .in_i(en[1]), .tx_if(if1),
        .clk_bps_i(tick[1]), .bps_start_o(bps[1]), .tx_o(txo[1]),
        .tx_busy_o(busy[1]), .tx_done_o(dn[1])
    );

    int total = 0;
    int bad   = 0;

    // Model: frame as a list of line levels, indexed by ticks seen since accept.
    // mexp packs {tx, bps_start, busy, done, ready}.
    logic [4:0] mexp [2] = '{5'b10000, 5'b10000};
    bit         mact [2] = '{1'b0, 1'b0};
    int         mk   [2] = '{0, 0};
    int         mN   [2] = '{0, 0};
    logic       mB   [2][0:15];
    int         mn;

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                mact[l] = 1'b0;
                mexp[l] = 5'b10000;
            end else if (!en[l]) begin
                mact[l] = 1'b0;
                mexp[l] = 5'b10000;
            end else if (mexp[l][1]) begin
                mexp[l] = 5'b10001;
            end else if (mact[l]) begin
                if (tick[l] === 1'b1) begin
                    mk[l]++;
                    if (mk[l] == mN[l] + 1) begin
                        mact[l] = 1'b0;
                        mexp[l] = 5'b10010;
                    end else begin
                        mexp[l] = {mB[l][mk[l]-1], 4'b1100};
                    end
                end
            end else if (valid[l] && mexp[l][0]) begin
                mB[l][0] = 1'b0;
                for (int i = 0; i < 8; i++) mB[l][1+i] = data[l][i];
                mn = 9;
                if (P == 1) begin
                    mB[l][mn] = (^data[l]) ^ (l == 1);
                    mn++;
                end
                for (int s = 0; s < l + 1; s++) begin
                    mB[l][mn] = 1'b1;
                    mn++;
                end
                mN[l]   = mn;
                mk[l]   = 0;
                mact[l] = 1'b1;
                mexp[l] = 5'b11100;
            end else begin
                mexp[l] = 5'b10001;
            end
        end
    end

    // Compare, line capture at each in-frame tick, and baud tick generation.
    logic       cap [2][0:4095];
    int         ncap [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         bcnt [2] = '{0, 0};
    int         per  [2] = '{15, 15};
    logic       bps_prev [2] = '{1'b0, 1'b0};
    bit         rnd = 1'b0;
    logic [4:0] got_v;

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            got_v = {txo[l], bps[l], busy[l], dn[l], rdy[l]};
            total++;
            if (got_v !== mexp[l]) begin
                bad++;
                $display("FAIL cycle_cmp lane%0d t=%0t got=%b want=%b",
                         l, $time, got_v, mexp[l]);
            end
            if (tick[l] === 1'b1 && bps_prev[l] === 1'b1 && ncap[l] < 4096) begin
                cap[l][ncap[l]] = txo[l];
                ncap[l]++;
            end
            if (dn[l] === 1'b1) done_cnt[l]++;
            bps_prev[l] = bps[l];
            if (bps[l] === 1'b1) begin
                if (bcnt[l] >= per[l]) begin
                    tick[l] = 1'b1;
                    bcnt[l] = 0;
                    if (rnd) per[l] = $urandom_range(0, 7);
                end else begin
                    tick[l] = 1'b0;
                    bcnt[l]++;
                end
            end else begin
                bcnt[l] = 0;
                tick[l] = rnd && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int l, input logic [7:0] d);
        int n = 0;
        while (rdy[l] !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        chk("send_ready_wait", 32'(rdy[l] === 1'b1), 1);
        data[l]  = d;
        valid[l] = 1'b1;
        step();
        valid[l] = 1'b0;
    endtask

    task automatic wait_done(input int l);
        int n = 0;
        while (dn[l] !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk("done_wait", 32'(dn[l] === 1'b1), 1);
    endtask

    task automatic wait_ticks(input int l, input int s, input int k);
        int n = 0;
        while (ncap[l] - s < k && n < 1000) begin
            step();
            n++;
        end
        chk("tick_wait", 32'(ncap[l] - s >= k), 1);
    endtask

    function automatic logic [7:0] dfield(input int l, input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = cap[l][s+1+i];
        return r;
    endfunction

    int i0;
    int i1;
    int dc;
    int n1;

    initial begin
        en    = '{1'b1, 1'b1};
        valid = '{1'b0, 1'b0};
        data  = '{8'h00, 8'h00};
        rst   = 1'b1;
        step();
        step();
        chk("rst_out0", {txo[0], bps[0], busy[0], dn[0], rdy[0]}, 5'b10000);
        chk("rst_out1", {txo[1], bps[1], busy[1], dn[1], rdy[1]}, 5'b10000);
        rst = 1'b0;
        step();
        chk("rst_ready", {rdy[0], rdy[1]}, 2'b11);

        i0 = ncap[0];
        send(0, 8'h55);
        chk("basic_accept", {bps[0], busy[0], rdy[0]}, 3'b110);
        wait_done(0);
        chk("basic_len", ncap[0] - i0, 11 + P);
        chk("basic_start", cap[0][i0], 0);
        chk("basic_data", dfield(0, i0), 8'h55);
        chk("basic_stop", cap[0][i0+9+P], 1);
        chk("basic_done_idle", {bps[0], busy[0]}, 2'b00);
        step();
        chk("basic_ready_after", {rdy[0], dn[0]}, 2'b10);

        i0 = ncap[0];
        dc = done_cnt[0];
        send(0, 8'hA3);
        repeat (40) step();
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        wait_done(0);
        chk("busy_len", ncap[0] - i0, 11 + P);
        chk("busy_data", dfield(0, i0), 8'hA3);
        n1 = ncap[0];
        repeat (300) step();
        chk("busy_one_frame", done_cnt[0] - dc, 1);
        chk("busy_no_line", ncap[0] - n1, 0);

        i0 = ncap[0];
        send(0, 8'h00);
        wait_ticks(0, i0, 4);
        en[0] = 1'b0;
        dc = done_cnt[0];
        step();
        chk("abort_out", {txo[0], bps[0], busy[0], dn[0], rdy[0]}, 5'b10000);
        repeat (30) step();
        chk("abort_no_done", done_cnt[0] - dc, 0);
        en[0] = 1'b1;
        step();
        chk("abort_ready", rdy[0], 1);
        i0 = ncap[0];
        send(0, 8'h0F);
        wait_done(0);
        chk("abort_next_len", ncap[0] - i0, 11 + P);
        chk("abort_next_data", dfield(0, i0), 8'h0F);

        i0 = ncap[1];
        send(1, 8'hC6);
        wait_ticks(1, i0, 4);
        rst = 1'b1;
        step();
        chk("rstmid_out1", {txo[1], bps[1], busy[1], dn[1], rdy[1]}, 5'b10000);
        chk("rstmid_out0", {txo[0], bps[0], busy[0], dn[0], rdy[0]}, 5'b10000);
        rst = 1'b0;
        step();
        chk("rstmid_ready", {rdy[0], rdy[1]}, 2'b11);

        i0 = ncap[1];
        send(1, 8'h81);
        wait_done(1);
        chk("stop2_len", ncap[1] - i0, 12 + P);
        chk("stop2_data", dfield(1, i0), 8'h81);
        chk("stop2_stops", {cap[1][i0+9+P], cap[1][i0+10+P]}, 2'b11);
        step();
        chk("b2b_ready", rdy[1], 1);
        i1 = ncap[1];
        send(1, 8'h3C);
        wait_done(1);
        chk("b2b_len", ncap[1] - i1, 12 + P);
        chk("b2b_start", cap[1][i1], 0);
        chk("b2b_data", dfield(1, i1), 8'h3C);

`ifdef UART_TX_PARITY_EN
        step();
        i0 = ncap[0];
        send(0, 8'h07);
        wait_done(0);
        chk("par_even_bit", cap[0][i0+9], 1);
        chk("par_even_len", ncap[0] - i0, 12);
        step();
        i0 = ncap[1];
        send(1, 8'h07);
        wait_done(1);
        chk("par_odd_bit", cap[1][i0+9], 0);
        chk("par_odd_len", ncap[1] - i0, 13);
`endif

        rnd = 1'b1;
        dc = done_cnt[0] + done_cnt[1];
        repeat (12000) begin
            rst = ($urandom_range(0, 999) == 0);
            for (int l = 0; l < 2; l++) begin
                en[l]    = ($urandom_range(0, 199) != 0);
                valid[l] = ($urandom_range(0, 2) == 0);
                data[l]  = 8'($urandom);
            end
            step();
        end
        chk("rand_frames", 32'(done_cnt[0] + done_cnt[1] - dc > 40), 1);

        rst   = 1'b0;
        en    = '{1'b1, 1'b1};
        valid = '{1'b0, 1'b0};
        rnd   = 1'b0;
        repeat (50) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
